// File: rtl/ts_word_packer_pkg.sv
// rtl/ts_word_packer_pkg.sv - shared TS constants and lane-count helper (package ts_pkg)
package ts_pkg;

  // Default width of one transport-stream symbol
  localparam int TS_MPEG_DATA_WIDTH = 8;

  // Transport-stream sync byte and packet length
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  // Number of symbol lanes in one output word
  function automatic int ts_lanes(input int out_width, input int data_width);
    return out_width / data_width;
  endfunction

endpackage

// File: rtl/ts_word_packer_if.sv
// rtl/ts_word_packer_if.sv - TS byte input, AXI-Stream word output and status bundle
interface ts_word_packer_if
  import ts_pkg::*;
#(
  parameter int MPEG_DATA_WIDTH = TS_MPEG_DATA_WIDTH,
  parameter int OUT_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 16
);

  localparam int LANES = ts_lanes(OUT_WIDTH, MPEG_DATA_WIDTH);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  logic                       ts_valid;
  logic                       ts_sync;
  logic [MPEG_DATA_WIDTH-1:0] ts_data;
  logic [OUT_WIDTH-1:0]       m_tdata;
  logic [LANES-1:0]           m_tkeep;
  logic                       m_tuser;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       overflow;
  logic [LW-1:0]              level;
`ifdef TS_WORD_PACKER_STATS_EN
  logic [31:0]                pkt_count;
  logic [31:0]                drop_count;
`endif

  // Packer side: consumes TS bytes, produces packed words
  modport master (
    input  ts_valid, ts_sync, ts_data, m_tready,
    output m_tdata, m_tkeep, m_tuser, m_tvalid, overflow, level
`ifdef TS_WORD_PACKER_STATS_EN
    , output pkt_count, drop_count
`endif
  );

  // Environment side: drives TS bytes, consumes packed words
  modport slave (
    output ts_valid, ts_sync, ts_data, m_tready,
    input  m_tdata, m_tkeep, m_tuser, m_tvalid, overflow, level
`ifdef TS_WORD_PACKER_STATS_EN
    , input pkt_count, drop_count
`endif
  );

endinterface

// File: rtl/ts_word_fifo.sv
// rtl/ts_word_fifo.sv - single-clock word buffer with full/empty/level
module ts_word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_level = r_count;
  // A pop frees the slot, so a push into a full buffer succeeds when both happen together
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Head word is forced to zero while empty so nothing stale is ever presented
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // Storage write; contents need no reset because reads are gated by the count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ts_word_packer.sv
// rtl/ts_word_packer.sv - packs TS bytes into AXI-Stream words; optional TS_WORD_PACKER_STATS_EN counters
module ts_word_packer
  import ts_pkg::*;
#(
  parameter int MPEG_DATA_WIDTH = TS_MPEG_DATA_WIDTH,
  parameter int OUT_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int BIG_ENDIAN      = 0
) (
  input logic             clk,
  input logic             rst,
  ts_word_packer_if.master bus
);

  localparam int         LANES = ts_lanes(OUT_WIDTH, MPEG_DATA_WIDTH);
  localparam int         DW    = MPEG_DATA_WIDTH;
  localparam logic [4:0] LAST  = 5'(LANES - 1);

  logic [4:0]           r_idx;
  logic [OUT_WIDTH-1:0] r_word;
  logic [LANES-1:0]     r_keep;
  logic                 r_user;
  logic                 r_push;
  logic [OUT_WIDTH-1:0] r_push_word;
  logic [LANES-1:0]     r_push_keep;
  logic                 r_push_user;
  logic                 r_overflow;

  logic                 w_flush;
  logic [4:0]           w_base_idx;
  logic [OUT_WIDTH-1:0] w_base_word;
  logic [LANES-1:0]     w_base_keep;
  logic                 w_base_user;
  logic [4:0]           w_lane;
  logic [OUT_WIDTH-1:0] w_word;
  logic [LANES-1:0]     w_keep;
  logic                 w_user;
  logic                 w_done;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_drop;

  // Merge the incoming byte into the partial word; a sync byte mid-word starts from a clean word
  always_comb begin
    w_flush     = bus.ts_valid && bus.ts_sync && (r_idx != 5'd0);
    w_base_idx  = w_flush ? 5'd0 : r_idx;
    w_base_word = w_flush ? '0 : r_word;
    w_base_keep = w_flush ? '0 : r_keep;
    w_base_user = w_flush ? 1'b0 : r_user;
    w_lane      = (BIG_ENDIAN != 0) ? (LAST - w_base_idx) : w_base_idx;
    w_word      = w_base_word;
    w_keep      = w_base_keep;
    for (int l = 0; l < LANES; l++) begin
      if (5'(l) == w_lane) begin
        w_word[l*DW +: DW] = bus.ts_data;
        w_keep[l]          = 1'b1;
      end
    end
    w_user = w_base_user | bus.ts_sync;
    w_done = (w_base_idx == LAST);
  end

  // Lane index, partial word and the one-deep push stage into the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_word      <= '0;
      r_keep      <= '0;
      r_user      <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
      r_push_keep <= '0;
      r_push_user <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (bus.ts_valid) begin
        if (w_flush) begin
          r_push      <= 1'b1;
          r_push_word <= r_word;
          r_push_keep <= r_keep;
          r_push_user <= r_user;
        end
        if (w_done) begin
          r_push      <= 1'b1;
          r_push_word <= w_word;
          r_push_keep <= w_keep;
          r_push_user <= w_user;
          r_idx       <= '0;
          r_word      <= '0;
          r_keep      <= '0;
          r_user      <= 1'b0;
        end else begin
          r_idx  <= w_base_idx + 5'd1;
          r_word <= w_word;
          r_keep <= w_keep;
          r_user <= w_user;
        end
      end
    end
  end

  assign w_pop  = !w_empty && bus.m_tready;
  assign w_drop = r_push && w_full && !w_pop;

  ts_word_fifo #(
    .WIDTH (OUT_WIDTH + LANES + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_data  ({r_push_user, r_push_keep, r_push_word}),
    .i_pop   (w_pop),
    .o_data  ({bus.m_tuser, bus.m_tkeep, bus.m_tdata}),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (bus.level)
  );

  assign bus.m_tvalid = !w_empty;
  assign bus.overflow = r_overflow;

  // Sticky flag for any word lost to a full buffer
  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef TS_WORD_PACKER_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_drop_count;

  // Saturating counts of accepted sync bytes and dropped words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (bus.ts_valid && bus.ts_sync && (r_pkt_count != '1)) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign bus.pkt_count  = r_pkt_count;
  assign bus.drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_ts_word_packer.sv
// tb/tb_ts_word_packer.sv - scoreboard bench for ts_word_packer (little- and big-endian instances)
module tb_ts_word_packer;
  import ts_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        u;
  } word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    errors = 0;
  int    checks = 0;
  word_t qa[$];
  word_t qb[$];
  word_t ea;
  word_t eb;

  always #5 clk = ~clk;

  ts_word_packer_if #(.MPEG_DATA_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4)) ia ();
  ts_word_packer_if #(.MPEG_DATA_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4)) ib ();

  ts_word_packer #(.MPEG_DATA_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4), .BIG_ENDIAN(0)) dut_le (
    .clk (clk), .rst (rst), .bus (ia)
  );
  ts_word_packer #(.MPEG_DATA_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4), .BIG_ENDIAN(1)) dut_be (
    .clk (clk), .rst (rst), .bus (ib)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pop and compare on every handshake, sampled mid-cycle
  always @(negedge clk) begin
    if (ia.m_tvalid && ia.m_tready) begin
      if (qa.size() == 0) check("a_unexpected_word", 64'(qa.size()), 64'd1);
      else begin
        ea = qa.pop_front();
        check("a_tdata", ia.m_tdata, ea.d);
        check("a_tkeep", ia.m_tkeep, ea.k);
        check("a_tuser", ia.m_tuser, ea.u);
      end
    end
    if (ib.m_tvalid && ib.m_tready) begin
      if (qb.size() == 0) check("b_unexpected_word", 64'(qb.size()), 64'd1);
      else begin
        eb = qb.pop_front();
        check("b_tdata", ib.m_tdata, eb.d);
        check("b_tkeep", ib.m_tkeep, eb.k);
        check("b_tuser", ib.m_tuser, eb.u);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic s, input logic [7:0] d);
    ia.ts_valid = 1'b1; ia.ts_sync = s; ia.ts_data = d;
    @(posedge clk); #1;
    ia.ts_valid = 1'b0; ia.ts_sync = 1'b0;
  endtask

  task automatic send_b(input logic s, input logic [7:0] d);
    ib.ts_valid = 1'b1; ib.ts_sync = s; ib.ts_data = d;
    @(posedge clk); #1;
    ib.ts_valid = 1'b0; ib.ts_sync = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] d, input logic [3:0] k, input logic u);
    qa.push_back({d, k, u});
  endtask

  task automatic push_b(input logic [31:0] d, input logic [3:0] k, input logic u);
    qb.push_back({d, k, u});
  endtask

  initial begin
    ia.ts_valid = 1'b0; ia.ts_sync = 1'b0; ia.ts_data = '0; ia.m_tready = 1'b1;
    ib.ts_valid = 1'b0; ib.ts_sync = 1'b0; ib.ts_data = '0; ib.m_tready = 1'b1;
    rst = 1'b1;
    idle(3);
    check("rst_tvalid", ia.m_tvalid, 0);
    check("rst_tdata", ia.m_tdata, 0);
    check("rst_tkeep", ia.m_tkeep, 0);
    check("rst_tuser", ia.m_tuser, 0);
    check("rst_overflow", ia.overflow, 0);
    check("rst_level", ia.level, 0);
    rst = 1'b0;

    // Full word with sync, latency to head
    push_a(32'h03020147, 4'hF, 1'b1);
    send_a(1'b1, TS_SYNC_BYTE); send_a(1'b0, 8'h01); send_a(1'b0, 8'h02); send_a(1'b0, 8'h03);
    check("latency_e0_tvalid", ia.m_tvalid, 0);
    idle(1);
    check("latency_e1_tvalid", ia.m_tvalid, 1);
    check("latency_head_tdata", ia.m_tdata, 32'h03020147);
    idle(3);

    // Sync mid-word flushes a partial word
    push_a(32'h00BBAA47, 4'h7, 1'b1);
    push_a(32'h03020147, 4'hF, 1'b1);
    send_a(1'b1, TS_SYNC_BYTE); send_a(1'b0, 8'hAA); send_a(1'b0, 8'hBB);
    send_a(1'b1, TS_SYNC_BYTE); send_a(1'b0, 8'h01); send_a(1'b0, 8'h02); send_a(1'b0, 8'h03);
    idle(4);

    // Idle gap mid-word holds the partial word; no sync -> tuser 0
    push_a(32'h40302010, 4'hF, 1'b0);
    send_a(1'b0, 8'h10);
    idle(3);
    send_a(1'b0, 8'h20); send_a(1'b0, 8'h30); send_a(1'b0, 8'h40);
    idle(4);
    check("drained_level", ia.level, 0);

    // Big-endian lane order, including a flushed partial word
    push_b(32'h11223344, 4'hF, 1'b0);
    push_b(32'h47AA0000, 4'hC, 1'b1);
    push_b(32'h47010203, 4'hF, 1'b1);
    send_b(1'b0, 8'h11); send_b(1'b0, 8'h22); send_b(1'b0, 8'h33); send_b(1'b0, 8'h44);
    send_b(1'b1, TS_SYNC_BYTE); send_b(1'b0, 8'hAA);
    send_b(1'b1, TS_SYNC_BYTE); send_b(1'b0, 8'h01); send_b(1'b0, 8'h02); send_b(1'b0, 8'h03);
    idle(4);

    // Overflow: 20 bytes into a 4-deep buffer with no consumer
    ia.m_tready = 1'b0;
    push_a(32'h04030201, 4'hF, 1'b0);
    push_a(32'h08070605, 4'hF, 1'b0);
    push_a(32'h0C0B0A09, 4'hF, 1'b0);
    push_a(32'h100F0E0D, 4'hF, 1'b0);
    for (int i = 0; i < 20; i++) send_a(1'b0, 8'(i + 1));
    idle(3);
    check("ovf_level", ia.level, 4);
    check("ovf_flag", ia.overflow, 1);
    check("ovf_head_tdata", ia.m_tdata, 32'h04030201);
    ia.m_tready = 1'b1;
    idle(8);
    check("ovf_drained_level", ia.level, 0);
    check("ovf_sticky", ia.overflow, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("ovf_cleared", ia.overflow, 0);

    // Full buffer, push and pop in the same cycle
    ia.m_tready = 1'b0;
    push_a(32'h04030201, 4'hF, 1'b0);
    push_a(32'h08070605, 4'hF, 1'b0);
    push_a(32'h0C0B0A09, 4'hF, 1'b0);
    push_a(32'h100F0E0D, 4'hF, 1'b0);
    push_a(32'h14131211, 4'hF, 1'b0);
    for (int i = 0; i < 16; i++) send_a(1'b0, 8'(i + 1));
    idle(2);
    check("full_level", ia.level, 4);
    for (int i = 16; i < 20; i++) send_a(1'b0, 8'(i + 1));
    ia.m_tready = 1'b1;
    idle(1);
    ia.m_tready = 1'b0;
    check("pushpop_level", ia.level, 4);
    check("pushpop_overflow", ia.overflow, 0);
    ia.m_tready = 1'b1;
    idle(8);
    check("pushpop_drained", ia.level, 0);

    // Reset mid-word discards the partial word
    send_a(1'b0, 8'hAA); send_a(1'b0, 8'hBB);
    rst = 1'b1;
    idle(2);
    check("midrst_tvalid", ia.m_tvalid, 0);
    check("midrst_tdata", ia.m_tdata, 0);
    check("midrst_tkeep", ia.m_tkeep, 0);
    check("midrst_tuser", ia.m_tuser, 0);
    check("midrst_level", ia.level, 0);
    rst = 1'b0;
    push_a(32'h04030201, 4'hF, 1'b0);
    send_a(1'b0, 8'h01); send_a(1'b0, 8'h02); send_a(1'b0, 8'h03); send_a(1'b0, 8'h04);
    idle(5);

    check("a_queue_empty", 64'(qa.size()), 0);
    check("b_queue_empty", 64'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_word_packer.md
TS_WORD_PACKER -- requirements
Module: ts_word_packer

Interface
REQ-001 Parameter MPEG_DATA_WIDTH, default 8, width of one TS symbol (byte lane).
REQ-002 Parameter OUT_WIDTH, default 32, output word width; SHALL be an integer multiple of MPEG_DATA_WIDTH, LANES = OUT_WIDTH / MPEG_DATA_WIDTH, 1..16.
REQ-003 Parameter FIFO_DEPTH, default 16, word buffer depth; power of two, >= 2.
REQ-004 Parameter BIG_ENDIAN, default 0; 0 = first byte in lane 0 (LSBs), 1 = first byte in lane LANES-1 (MSBs).
REQ-005 Single clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; TS input and AXI-Stream output both in this domain.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ts_valid  in  1  ts_data/ts_sync qualify this cycle.
REQ-009 ts_sync  in  1  current byte is the first byte of a TS packet.
REQ-010 ts_data  in  MPEG_DATA_WIDTH  TS byte.
REQ-011 m_tdata  out  OUT_WIDTH  packed word.
REQ-012 m_tkeep  out  LANES  one bit per lane, 1 = lane holds a real byte.
REQ-013 m_tuser  out  1  word contains a packet-start (sync) byte.
REQ-014 m_tvalid  out  1 / m_tready  in  1  AXI-Stream handshake.
REQ-015 overflow  out  1  sticky: a word was dropped because the buffer was full.
REQ-016 level  out  $clog2(FIFO_DEPTH)+1  buffered word count.

Function
REQ-017 Packer keeps a lane index 0..LANES-1; each ts_valid byte is written to the lane given by the index (per BIG_ENDIAN) and sets that keep bit.
REQ-018 When the byte fills lane index LANES-1, the word SHALL be pushed to the buffer on the next clock with m_tkeep all ones and the index SHALL return to 0.
REQ-019 ts_sync with index != 0: the partial word SHALL be pushed with keep covering only filled lanes, unfilled lanes zero in m_tdata; the sync byte SHALL start a new word at index 0 in the same cycle.
REQ-020 ts_sync with index == 0: no flush; the byte starts a word normally.
REQ-021 The word containing a sync byte SHALL carry m_tuser = 1; all others 0.
REQ-022 ts_valid low: index, partial word and keep SHALL hold; no timeout flush.
REQ-023 Latency: word at output head, m_tvalid asserted, 2 clocks after the byte completing it, buffer empty.
REQ-024 Word pops on m_tvalid && m_tready; m_tdata/m_tkeep/m_tuser SHALL stay stable while m_tvalid && !m_tready.
REQ-025 Buffer full, push without pop in same cycle: word SHALL be dropped, overflow set and held until rst.
REQ-026 Buffer full, push and pop in same cycle: both SHALL succeed, level unchanged, no overflow.
REQ-027 Buffer empty: m_tvalid = 0; a push SHALL NOT bypass to the output in the same cycle.
REQ-028 Pointers wrap modulo FIFO_DEPTH; level SHALL count 0..FIFO_DEPTH exactly.

Reset
REQ-029 On rst: index 0, partial word and keep cleared, buffer emptied, m_tvalid 0, m_tdata 0, m_tkeep 0, m_tuser 0, overflow 0, level 0.
REQ-030 rst mid-word SHALL discard the partial word; first byte after reset lands in index 0.

Configuration
REQ-031 Macro TS_WORD_PACKER_STATS_EN defined: adds outputs pkt_count (32 bits, +1 per accepted sync byte) and drop_count (32 bits, +1 per dropped word), both saturating at all ones, cleared by rst.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package ts_pkg SHALL hold MPEG_DATA_WIDTH default, the TS sync value 8'h47 and packet length 188 constants, and a lane-count helper function.
REQ-034 Buffer SHALL be sub-module ts_word_fifo (single-clock, data+keep+user, full/empty/level); packing logic stays in ts_word_packer.

Verification
REQ-035 OUT_WIDTH 32, BIG_ENDIAN 0, bytes 47,01,02,03 (sync on 47), m_tready 1 -> one word 0x03020147, keep 4'hF, tuser 1, m_tvalid 2 clocks after byte 03.
REQ-036 Bytes 47,AA,BB then sync 47 -> word 0x00BBAA47 keep 4'h7 tuser 1, then new word starting 0x47 in lane 0.
REQ-037 BIG_ENDIAN 1, bytes 11,22,33,44 -> 0x11223344, keep 4'hF.
REQ-038 m_tready 0, FIFO_DEPTH 4, stream 20 bytes -> level 4, 1 drop, overflow 1 and stays 1 after m_tready 1 until rst; first four words intact.
REQ-039 Full buffer, push and pop same cycle -> level stays 4, overflow 0.
REQ-040 rst asserted after 2 bytes of a word -> all outputs 0; next bytes 01..04 produce 0x04030201.
